remote_player_rx: RTL

- Sits between the three-channel UART controller and the remote-player draw stage.
- Collects the three received position bytes into one coherent remote-player record: x, y and level.
- Range-checks the record and commits it to its outputs only at a vertical-blanking boundary, so the remote sprite never tears mid-frame.
- Tracks link liveness so the draw stage can hide a silent remote player.

---
 rtl/remote_player_rx.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/remote_player_rx.sv
// Remote-player receiver: assembles the three UART position bytes into an x/y/level
// record, range-checks it and commits at vblnk rising edges. Optional REMOTE_RX_ERR_CNT_EN.

module remote_player_rx_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data,
  input  logic       done,
  input  logic       flush,
  output logic       pend,
  output logic       pend_eff,
  output logic [7:0] byte_eff
);
  logic [7:0] byte_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend   <= 1'b0;
      byte_q <= 8'd0;
    end else begin
      if (valid) byte_q <= data;
      // a strobe landing on a timeout cycle starts the next record
      if (done)       pend <= 1'b0;
      else if (flush) pend <= valid;
      else if (valid) pend <= 1'b1;
    end
  end

  assign pend_eff = pend | valid;
  assign byte_eff = valid ? data : byte_q;
endmodule

module remote_player_rx #(
  parameter int SKEW_TIMEOUT = 1024,
  parameter int LOST_FRAMES  = 60,
  parameter int X_MAX        = 1023,
  parameter int Y_MAX        = 767
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_1,
  input  logic [7:0]  data_2,
  input  logic [7:0]  data_3,
  input  logic        valid_1,
  input  logic        valid_2,
  input  logic        valid_3,
  input  logic        vblnk,
  output logic [11:0] x_value,
  output logic [11:0] y_value,
  output logic [1:0]  level_remote,
  output logic        remote_present,
  output logic [7:0]  err_count
);
  localparam int NUM_LANES = 3;
  localparam int SW = $clog2(SKEW_TIMEOUT + 1);
  localparam int FW = $clog2(LOST_FRAMES + 1);
  localparam logic [11:0] X_LIM = 12'(X_MAX);
  localparam logic [11:0] Y_LIM = 12'(Y_MAX);

  logic [NUM_LANES-1:0][7:0] data_v, byte_eff;
  logic [NUM_LANES-1:0]      valid_v, pend, pend_eff;
  logic                      complete, skew_to, in_range, commit;
  logic [11:0]               x_rec, y_rec;
  logic [SW-1:0]             skew_cnt;
  logic [FW-1:0]             frame_cnt;
  logic [11:0]               stg_x, stg_y;
  logic [1:0]                stg_lvl;
  logic                      staged_valid, vblnk_q;

  assign data_v  = {data_3, data_2, data_1};
  assign valid_v = {valid_3, valid_2, valid_1};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    remote_player_rx_lane u_lane (
      .clk      (clk),
      .rst      (rst),
      .valid    (valid_v[i]),
      .data     (data_v[i]),
      .done     (complete),
      .flush    (skew_to),
      .pend     (pend[i]),
      .pend_eff (pend_eff[i]),
      .byte_eff (byte_eff[i])
    );
  end

  assign complete = &pend_eff;
  assign skew_to  = !complete && (|pend) && (skew_cnt == SW'(SKEW_TIMEOUT - 1));
  assign x_rec    = {1'b0, byte_eff[1][2:0], byte_eff[0]};
  assign y_rec    = {1'b0, byte_eff[2][5:0], byte_eff[1][7:3]};
  assign in_range = (x_rec <= X_LIM) && (y_rec <= Y_LIM);
  assign commit   = vblnk && !vblnk_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skew_cnt <= '0;
    end else if (complete || skew_to || !(|pend)) begin
      skew_cnt <= '0;
    end else begin
      skew_cnt <= skew_cnt + 1'b1;
    end
  end

  // commit reads the pre-cycle staged copy; a same-cycle completion waits for the next edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vblnk_q        <= 1'b0;
      stg_x          <= '0;
      stg_y          <= '0;
      stg_lvl        <= '0;
      staged_valid   <= 1'b0;
      frame_cnt      <= '0;
      x_value        <= '0;
      y_value        <= '0;
      level_remote   <= '0;
      remote_present <= 1'b0;
    end else begin
      vblnk_q <= vblnk;
      if (commit) begin
        if (staged_valid) begin
          x_value        <= stg_x;
          y_value        <= stg_y;
          level_remote   <= stg_lvl;
          remote_present <= 1'b1;
          frame_cnt      <= '0;
          staged_valid   <= 1'b0;
        end else if (frame_cnt != FW'(LOST_FRAMES)) begin
          frame_cnt <= frame_cnt + 1'b1;
          if (frame_cnt == FW'(LOST_FRAMES - 1)) remote_present <= 1'b0;
        end
      end
      if (complete && in_range) begin
        stg_x        <= x_rec;
        stg_y        <= y_rec;
        stg_lvl      <= byte_eff[2][7:6];
        staged_valid <= 1'b1;
      end
    end
  end

`ifdef REMOTE_RX_ERR_CNT_EN
  logic [7:0] err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 8'd0;
    end else if (((complete && !in_range) || skew_to) && err_q != 8'hFF) begin
      err_q <= err_q + 8'd1;
    end
  end
  assign err_count = err_q;
`else
  assign err_count = 8'd0;
`endif
endmodule
